// File: rtl/cdb_broadcaster_if.sv
// Bus bundle for the CDB broadcaster: per-source result handshake plus the broadcast channel.
// master = result producers / bus watchers, slave = the broadcaster itself.
interface cdb_broadcaster_if #(
  parameter int NSRC = 3
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]    src_valid;
  logic [5*NSRC-1:0]  src_label;
  logic [32*NSRC-1:0] src_data;
  logic [NSRC-1:0]    src_ready;
  logic               BCEN;
  logic [4:0]         BClabel;
  logic [31:0]        BCdata;
  logic [SW-1:0]      BCsrc;
  logic               drop_err;

  modport master (
    output src_valid, src_label, src_data,
    input  src_ready, BCEN, BClabel, BCdata, BCsrc, drop_err
  );

  modport slave (
    input  src_valid, src_label, src_data,
    output src_ready, BCEN, BClabel, BCdata, BCsrc, drop_err
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common Data Bus transmitter: per-source FIFOs, round-robin arbiter, registered broadcast.
// A result enqueued at edge E is on the bus after edge E+1; src_ready is registered (full => 0, no pop pass-through).
module cdb_broadcaster #(
  parameter int NSRC  = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  cdb_broadcaster_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [4:0]    lbl_mem_q [NSRC][DEPTH];
  logic [31:0]   dat_mem_q [NSRC][DEPTH];
  logic [AW-1:0] wr_q  [NSRC];
  logic [AW-1:0] wr_d  [NSRC];
  logic [AW-1:0] rd_q  [NSRC];
  logic [AW-1:0] rd_d  [NSRC];
  logic [AW:0]   cnt_q [NSRC];
  logic [AW:0]   cnt_d [NSRC];
  logic [SW-1:0] ptr_q, ptr_d;
  logic          bcen_q;
  logic [4:0]    bclabel_q;
  logic [31:0]   bcdata_q;
  logic [SW-1:0] bcsrc_q;
  logic          drop_q, drop_d;

  logic [NSRC-1:0] rdy, xfer, push, pop, nonempty;
  logic            any_vld;
  logic [SW-1:0]   win;
  logic [SW:0]     idx;
  logic [4:0]      head_lbl;
  logic [31:0]     head_dat;

  always_comb begin
    rdy      = '0;
    nonempty = '0;
    xfer     = '0;
    push     = '0;
    for (int i = 0; i < NSRC; i++) begin
      rdy[i]      = cnt_q[i] < (AW+1)'(DEPTH);
      nonempty[i] = cnt_q[i] != '0;
      xfer[i]     = bus.src_valid[i] && rdy[i];
      // Label 0 means "no producer": the transfer completes but nothing is queued.
      push[i]     = xfer[i] && (bus.src_label[5*i +: 5] != 5'd0);
    end
  end

  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = {1'b0, ptr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(NSRC)) idx = idx - (SW+1)'(NSRC);
      if (!any_vld && nonempty[idx[SW-1:0]]) begin
        any_vld = 1'b1;
        win     = idx[SW-1:0];
      end
    end
  end

  assign head_lbl = lbl_mem_q[win][rd_q[win]];
  assign head_dat = dat_mem_q[win][rd_q[win]];

  always_comb begin
    pop    = '0;
    ptr_d  = ptr_q;
    drop_d = drop_q | (|(xfer & ~push));
    for (int i = 0; i < NSRC; i++) begin
      pop[i]   = any_vld && (win == SW'(i));
      wr_d[i]  = push[i] ? wr_q[i] + AW'(1) : wr_q[i];
      rd_d[i]  = pop[i]  ? rd_q[i] + AW'(1) : rd_q[i];
      cnt_d[i] = cnt_q[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + (AW+1)'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - (AW+1)'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    if (any_vld) ptr_d = (win == SW'(NSRC-1)) ? '0 : win + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      ptr_q     <= '0;
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      bcsrc_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
      end
      ptr_q  <= ptr_d;
      bcen_q <= any_vld;
      drop_q <= drop_d;
      if (any_vld) begin
        bclabel_q <= head_lbl;
        bcdata_q  <= head_dat;
        bcsrc_q   <= win;
      end else begin
        bclabel_q <= '0;
      end
    end
  end

  // Storage needs no reset: entries are only visible through the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        lbl_mem_q[i][wr_q[i]] <= bus.src_label[5*i +: 5];
        dat_mem_q[i][wr_q[i]] <= bus.src_data[32*i +: 32];
      end
    end
  end

  assign bus.src_ready = rdy;
  assign bus.BCEN      = bcen_q;
  assign bus.BClabel   = bclabel_q;
  assign bus.BCdata    = bcdata_q;
  assign bus.BCsrc     = bcsrc_q;
  assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: vector table plus a backpressure sequence.
module tb_cdb_broadcaster;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NSRC(3)) bus ();
  cdb_broadcaster #(.NSRC(3), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [4:0]  l0, l1, l2;
    logic [31:0] d0, d1, d2;
    logic        e_en;
    logic [4:0]  e_lbl;
    logic [31:0] e_dat;
    logic [1:0]  e_src;
    logic [2:0]  e_rdy;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  int         nsend [3];
  int         exp_seq [3];
  logic [2:0] acc;
  logic [2:0] v;
  int         last0;
  int         s;
  logic       saw_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] vl,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                              input logic en, input logic [4:0] lbl, input logic [31:0] dat,
                              input logic [1:0] src, input logic [2:0] rdy, input logic drop);
    vec_t t;
    t.rst = r; t.vld = vl; t.l0 = a0; t.l1 = a1; t.l2 = a2;
    t.d0 = b0; t.d1 = b1; t.d2 = b2;
    t.e_en = en; t.e_lbl = lbl; t.e_dat = dat; t.e_src = src; t.e_rdy = rdy; t.e_drop = drop;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [2:0] vl,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    rst            = r;
    bus.src_valid  = vl;
    bus.src_label  = {a2, a1, a0};
    bus.src_data   = {b2, b1, b0};
  endtask

  initial begin
    // reset then idle
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    // single result from src1
    vecs.push_back(mk(0, 3'b010, 0, 4, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 32'hDEADBEEF, 1, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 3'b111, 0));
    // round robin from a fresh pointer
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'h100, 32'h200, 32'h300, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b111, 4, 5, 6, 32'h400, 32'h500, 32'h600, 1, 1, 32'h100, 0, 3'b001, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 32'h200, 1, 3'b011, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 3, 32'h300, 2, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 32'h400, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 5, 32'h500, 1, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 6, 32'h600, 2, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600, 2, 3'b111, 0));
    // label 0 is swallowed and flagged
    vecs.push_back(mk(0, 3'b100, 0, 0, 0, 0, 0, 7, 0, 0, 32'h600, 2, 3'b111, 1));
    vecs.push_back(mk(0, 3'b100, 0, 0, 9, 0, 0, 9, 0, 0, 32'h600, 2, 3'b111, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 9, 2, 3'b111, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2, 3'b111, 1));
    // reset with five results queued and a simultaneous push
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2, 3, 11, 12, 13, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b111, 4, 5, 6, 14, 15, 16, 1, 1, 11, 0, 3'b001, 0));
    vecs.push_back(mk(1, 3'b111, 7, 8, 9, 17, 18, 19, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b101, 21, 0, 22, 21, 0, 22, 0, 0, 0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 21, 21, 0, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 22, 22, 2, 3'b111, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 22, 2, 3'b111, 0));

    // Each row is driven at a negedge, consumed at the next posedge, checked at the following negedge.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].l0, vecs[i].l1, vecs[i].l2,
            vecs[i].d0, vecs[i].d1, vecs[i].d2);
      @(negedge clk);
      chk($sformatf("v%0d.BCEN", i),      32'(bus.BCEN),      32'(vecs[i].e_en));
      chk($sformatf("v%0d.BClabel", i),   32'(bus.BClabel),   32'(vecs[i].e_lbl));
      chk($sformatf("v%0d.BCdata", i),    bus.BCdata,         vecs[i].e_dat);
      chk($sformatf("v%0d.BCsrc", i),     32'(bus.BCsrc),     32'(vecs[i].e_src));
      chk($sformatf("v%0d.src_ready", i), 32'(bus.src_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.drop_err", i),  32'(bus.drop_err),  32'(vecs[i].e_drop));
    end

    // Backpressure: src0 sends 4 results while src1/src2 stream continuously.
    drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nsend[i]   = 0;
      exp_seq[i] = 0;
    end
    acc      = 3'b000;
    last0    = -1;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int i = 0; i < 3; i++)
        if (acc[i]) nsend[i]++;
      v[0] = (nsend[0] < 4);
      v[1] = (cyc < 25);
      v[2] = (cyc < 25);
      drive(0, v, 5'(10 + nsend[0]), 5'(20 + nsend[1] % 5), 5'(25 + nsend[2] % 5),
            32'(nsend[0]), 32'((1 << 16) | nsend[1]), 32'((2 << 16) | nsend[2]));
      acc = v & bus.src_ready;
      if (v[0] && !bus.src_ready[0]) saw_full = 1'b1;
      @(negedge clk);
      if (bus.BCEN) begin
        s = int'(bus.BCsrc);
        if (s < 3) begin
          chk($sformatf("bp.order.src%0d", s), bus.BCdata, 32'((s << 16) | exp_seq[s]));
          if (s == 0) begin
            chk("bp.src0.label", 32'(bus.BClabel), 32'(10 + exp_seq[0]));
            if (last0 >= 0) chk("bp.src0.gap_le3", 32'(cyc - last0 <= 3), 32'd1);
            last0 = cyc;
          end
          exp_seq[s]++;
        end else begin
          chk("bp.BCsrc_range", 32'(s), 32'd0);
        end
      end
    end
    chk("bp.ready0_dropped", 32'(saw_full), 32'd1);
    chk("bp.src0.count", 32'(exp_seq[0]), 32'd4);
    chk("bp.src1.count", 32'(exp_seq[1]), 32'(nsend[1]));
    chk("bp.src2.count", 32'(exp_seq[2]), 32'(nsend[2]));
    chk("bp.idle_after_drain", 32'(bus.BCEN), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Common Data Bus transmitter. Collects results from the functional units (ALU, load unit, multiplier) and drives the single broadcast channel (BCEN/BClabel/BCdata) watched by every reservation station and the register status table.
- Each source gets a small per-source FIFO. A round-robin arbiter grants one result per cycle to the bus.

Parameters:
- NSRC, 3, number of result sources (index 0 = ALU, 1 = load, 2 = mult).
- DEPTH, 2, entries per source FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  NSRC  source i presents a result.
- src_label  in  5*NSRC  station label of source i, bits [5i+4:5i].
- src_data  in  32*NSRC  result value of source i, bits [32i+31:32i].
- src_ready  out  NSRC  FIFO i can accept this cycle.
- BCEN  out  1  broadcast valid (registered).
- BClabel  out  5  broadcast label (registered).
- BCdata  out  32  broadcast value (registered).
- BCsrc  out  2  index of the source being broadcast (registered, debug/stats).
- drop_err  out  1  sticky: a label-0 result was offered.

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs are emptied.
  - BCEN=0, BClabel=0, BCdata=0, BCsrc=0, drop_err=0.
  - The round-robin pointer is reset so source 0 has highest priority.
  - Reset overrides every simultaneous push/pop. Results in flight are lost.
- Handshake:
  - src_ready[i] = (count_i < DEPTH). It comes from registered count only and does not depend on a same-cycle pop.
  - A transfer happens at a posedge when src_valid[i] && src_ready[i].
  - A source holds valid/label/data stable until it sees ready.
- Label 0:
  - Label 0 means "no producer" to the stations.
  - A transfer with label 0 is accepted but not written to the FIFO.
  - It sets drop_err, which stays set until rst.
- FIFO:
  - Circular, with wr/rd pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - A push and a pop in the same cycle leave count unchanged.
  - Pop only when count>0.
- Arbitration (combinational, on the FIFO heads):
  - Candidates are sources with count_i>0.
  - Search starts at pointer p and goes p, p+1, …, wrapping modulo NSRC. The first candidate wins.
  - At the posedge the winner's head is popped, and p ← winner+1 (mod NSRC).
  - If there are no candidates, p is unchanged.
- Output register:
  - At each posedge: BCEN ← any candidate.
  - If BCEN goes high, BClabel/BCdata/BCsrc ← winner's head.
  - Otherwise BClabel ← 0, and BCdata/BCsrc hold their previous values.
  - BCEN is high for exactly one cycle per result.
- Latency:
  - A result accepted at posedge E into an empty FIFO with no competitors appears with BCEN=1 during the cycle after posedge E+1.
  - Throughput is 1 broadcast/cycle total.
- Fairness: under continuous contention each non-empty source is served at least once every NSRC cycles.
- Ordering: results from the same source are broadcast in acceptance order. There is no ordering guarantee across sources.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle. This trades one bubble for a registered ready.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valid → BCEN=0, BClabel=0, src_ready=3'b111, drop_err=0 for 10 cycles.
- Single result: src1 valid, label=5'd4, data=32'hDEADBEEF accepted at edge E → BCEN=1, BClabel=4, BCdata=DEADBEEF, BCsrc=1 for exactly one cycle after edge E+1, then BCEN=0.
- Round-robin: all three sources push labels 1/2/3 at the same edge, then 4/5/6 next edge → broadcast order 1,2,3,4,5,6 with BCsrc 0,1,2,0,1,2 on consecutive cycles, no gaps.
- Backpressure/full: src0 pushes 4 results back-to-back while src1/src2 keep their FIFOs full → src_ready[0] drops to 0 once count0=2; no result lost; src0's labels emerge in order, at most 3 cycles apart.
- Label 0: src2 offers label 0, data 7 → accepted (ready=1), never broadcast, drop_err=1 next cycle and stays 1; the next src2 result, label 9, is broadcast normally.
- Reset mid-operation: FIFOs holding 5 results, rst=1 for one cycle → BCEN=0 next cycle, counts=0, src_ready all 1, pointer back at source 0 (a simultaneous push from src2 then src0 is broadcast src0 first).
